sprite_line_fetcher: RTL and testbench
======================================

# sprite_line_fetcher

Per-scanline sprite fetch-and-draw stage that consumes a 256×16 single-port sprite ROM, such as the fire sprite memories. The ROM holds a 16×16 sprite with one 16-bit colour word per pixel. During horizontal blanking the block reads one sprite row into a local 16-entry line buffer. During active video it emits that row's opaque pixels at the sprite's x position to the downstream VGA compositor.

## Interface
- `SPRITE_W`, default 16: sprite width in pixels; fixed at 16 for this ROM geometry.
- `SPRITE_H`, default 16: sprite height in lines.
- `TRANSPARENT`, default 16'h0000: colour value that is never emitted.
- `clk` input, 1 bit: system clock. All logic is in this domain.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `sprite_en` input, 1 bit: sprite visible.
- `sprite_x` input, 11 bits: left column of the sprite on screen.
- `sprite_y` input, 10 bits: top line of the sprite on screen.
- `line_start` input, 1 bit: one-cycle pulse at the start of the hblank that precedes line `next_line`.
- `next_line` input, 10 bits: line about to be displayed.
- `hcount` input, 11 bits: current pixel column.
- `hactive` input, 1 bit: high while `hcount` is in the visible region.
- `rom_address` output, 8 bits: sprite ROM address.
- `rom_clken` output, 1 bit: sprite ROM clock enable.
- `rom_readdata` input, 16 bits: sprite ROM data. Valid one cycle after the address is registered.
- `busy` output, 1 bit: fetch in progress.
- `fetch_done` output, 1 bit: one-cycle pulse when the line buffer is final for `next_line`.
- `pix_valid` output, 1 bit: opaque sprite pixel present.
- `pix_color` output, 16 bits: pixel colour; valid when `pix_valid` is high.

## Operation
- State machine with three states:
  - IDLE → FETCH on `line_start` when the line hits the sprite.
  - FETCH → LAST after address 15 has been issued.
  - LAST → IDLE after word 15 has been captured.
- On `line_start`, latch `sprite_x` into `x_l` and evaluate the hit.
  - hit = `sprite_en` & (`next_line` ≥ `sprite_y`) & (`next_line` < `sprite_y` + 16).
  - Compare in 11 bits so that a `sprite_y` near 1023 does not wrap.
  - row = (`next_line` − `sprite_y`)[3:0].
- Miss: `line_hit` is cleared, no ROM access is made, and `fetch_done` pulses on the next cycle.
- Hit: `line_hit` is set. The block issues address {row, k} for k = 0..15 on consecutive cycles with `rom_clken` = 1. Each `rom_readdata` word is written to `buf[k]` one cycle after its address.
- `line_start` in any state other than IDLE aborts the current fetch and restarts for the new line, applying the same hit evaluation. Partially written buffer contents are overwritten.
- Pixel path, registered:
  - Let d = `hcount` − `x_l`, computed in 12-bit signed arithmetic.
  - If `hactive` & `line_hit` & 0 ≤ d < 16 & `buf[d]` ≠ `TRANSPARENT`, then `pix_valid` = 1 and `pix_color` = `buf[d]` on the next cycle.
  - Otherwise `pix_valid` = 0 and `pix_color` holds its previous value.
- While `busy` is high, `pix_valid` is forced to 0.
- Reset values:
  - State IDLE.
  - `busy`, `fetch_done`, `pix_valid`, `rom_clken`, `line_hit`: 0.
  - `rom_address`, `pix_color`, `x_l`: 0.
  - Buffer contents are don't-care, because `line_hit` = 0 masks them.
- Reset asserted mid-fetch returns the block to the reset values immediately. No further ROM reads occur.

## Timing
- Take the `line_start` cycle as cycle 0.
- Hit case:
  - Cycles 1..16: `rom_address` = {row, k−1}, `rom_clken` = 1, `busy` = 1.
  - Word k is captured at the end of cycle k+2.
  - Cycle 17 is state LAST: `rom_clken` = 0, `busy` = 1.
  - Cycle 18: `fetch_done` = 1, `busy` = 0.
  - Total latency is 18 cycles, which must fit within hblank.
- Miss case: `fetch_done` = 1 in cycle 1; `busy` stays 0.
- Pixel latency is 1 cycle from `hcount`/`hactive` to `pix_valid`/`pix_color`.
- `line_start` and `reset` asserted on the same edge: reset wins.

## Structure
- A shared package `sprite_pkg` holds:
  - The state enum: IDLE, FETCH, LAST.
  - `SPRITE_W`, `SPRITE_H`, ROM address width 8, colour width 16.
  - The default transparent colour.
- One sub-module, `sprite_line_buf`: a 16×16 register file with one synchronous write port and one combinational read port.
- The FSM, hit logic and pixel path live in the top module.

## Test plan
- Hit fetch: ROM word a = a; `sprite_y` = 100, `next_line` = 103, `line_start` → addresses 0x30..0x3F in cycles 1–16, `fetch_done` in cycle 18, `buf[k]` = 0x30 + k.
- Pixel draw: after the hit-fetch case, `sprite_x` = 200, sweep `hcount` 190..220 with `hactive` = 1 → `pix_valid` high for `hcount` 200..215, one cycle later, with `pix_color` = 0x30..0x3F.
- Transparency and miss:
  - ROM word 0x35 = 0x0000 → no pixel is emitted at `hcount` 205.
  - `next_line` = 116 with `sprite_y` = 100 → miss: no ROM access, `fetch_done` in cycle 1, `pix_valid` never asserted.
- Boundary: `sprite_y` = 1020, `next_line` = 5 → miss, with no wrap-around hit. `sprite_x` = 0 → pixels at `hcount` 0..15.
- Abort: second `line_start` (`next_line` = 104) at cycle 7 → new addresses 0x40..0x4F start the next cycle, `fetch_done` 18 cycles after the second pulse, buffer holds row 4.
- Reset at cycle 9 of a fetch → `busy`, `rom_clken`, `pix_valid` and `fetch_done` go to 0 immediately; no `fetch_done` pulse follows.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line fetcher.
//   state_t           : fetch FSM state encoding
//   SPRITE_W_DEF      : sprite width in pixels (ROM geometry fixes this at 16)
//   SPRITE_H_DEF      : sprite height in lines
//   ROM_AW / COLOR_W  : sprite ROM address and colour word widths
//   TRANSPARENT_DEF   : colour that is never emitted
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LAST  = 2'd2
  } state_t;

  localparam int SPRITE_W_DEF = 16;
  localparam int SPRITE_H_DEF = 16;
  localparam int ROM_AW       = 8;
  localparam int COLOR_W      = 16;

  localparam logic [COLOR_W-1:0] TRANSPARENT_DEF = 16'h0000;

endpackage

// File: rtl/sprite_line_buf.sv
// 16-entry line buffer holding one sprite row.
//   clk          : system clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : combinational read port
// No reset: contents are masked downstream until a fetch completes.
module sprite_line_buf
  import sprite_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [3:0]         waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic [3:0]         raddr,
  output logic [COLOR_W-1:0] rdata
);

  logic [COLOR_W-1:0] mem [16];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite fetch-and-draw stage.
// During hblank one sprite row is read from the sprite ROM into a local
// line buffer; during active video the row's opaque pixels are emitted.
//   clk, reset                : system clock, async active-high reset
//   sprite_en/x/y             : sprite visibility and screen position
//   line_start, next_line     : hblank pulse and the line about to be shown
//   hcount, hactive           : current pixel column and visible flag
//   rom_address/clken/readdata: sprite ROM port (registered-address ROM)
//   busy, fetch_done          : fetch status / end-of-fetch pulse
//   pix_valid, pix_color      : registered pixel output to the compositor
//
// state | meaning
// IDLE  | no fetch in progress; line buffer final (or line missed)
// FETCH | issuing ROM addresses {row, 0..15}
// LAST  | waiting for the final ROM word to land in the buffer
module sprite_line_fetcher
  import sprite_pkg::*;
#(
  parameter int                 SPRITE_W    = SPRITE_W_DEF,
  parameter int                 SPRITE_H    = SPRITE_H_DEF,
  parameter logic [COLOR_W-1:0] TRANSPARENT = TRANSPARENT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sprite_en,
  input  logic [10:0]        sprite_x,
  input  logic [9:0]         sprite_y,
  input  logic               line_start,
  input  logic [9:0]         next_line,
  input  logic [10:0]        hcount,
  input  logic               hactive,
  output logic [ROM_AW-1:0]  rom_address,
  output logic               rom_clken,
  input  logic [COLOR_W-1:0] rom_readdata,
  output logic               busy,
  output logic               fetch_done,
  output logic               pix_valid,
  output logic [COLOR_W-1:0] pix_color
);

  state_t             state, state_nxt;
  logic               fetch_done_nxt;
  logic               line_hit;
  logic [10:0]        x_l;
  logic               hit;
  logic [3:0]         row;
  logic [10:0]        ny, sy;
  logic               wr_en;
  logic [3:0]         wr_idx;
  logic [11:0]        d;
  logic               in_range;
  logic [COLOR_W-1:0] rd_data;
  logic               opaque;
  logic               pix_valid_r;

  // 11-bit compare so a sprite near the bottom of the frame does not wrap
  assign ny  = {1'b0, next_line};
  assign sy  = {1'b0, sprite_y};
  assign hit = sprite_en && (ny >= sy) && (ny < sy + 11'(SPRITE_H));
  assign row = 4'(next_line - sprite_y);

  assign busy      = (state != IDLE);
  assign rom_clken = (state == FETCH);

  always_comb begin
    state_nxt      = state;
    fetch_done_nxt = 1'b0;
    if (line_start) begin
      if (hit) begin
        state_nxt = FETCH;
      end else begin
        state_nxt      = IDLE;
        fetch_done_nxt = 1'b1;
      end
    end else begin
      case (state)
        FETCH: if (rom_address[3:0] == 4'hF) state_nxt = LAST;
        LAST: begin
          state_nxt      = IDLE;
          fetch_done_nxt = 1'b1;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fetch_done  <= 1'b0;
      rom_address <= '0;
      line_hit    <= 1'b0;
      x_l         <= '0;
      wr_en       <= 1'b0;
      wr_idx      <= '0;
    end else begin
      state      <= state_nxt;
      fetch_done <= fetch_done_nxt;
      // ROM data arrives one cycle after the address, so delay the index
      wr_en      <= rom_clken;
      wr_idx     <= rom_address[3:0];
      if (line_start) begin
        x_l      <= sprite_x;
        line_hit <= hit;
        if (hit) rom_address <= {row, 4'h0};
      end else if (state == FETCH && rom_address[3:0] != 4'hF) begin
        rom_address <= rom_address + 8'd1;
      end
    end
  end

  sprite_line_buf u_line_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_idx),
    .wdata (rom_readdata),
    .raddr (d[3:0]),
    .rdata (rd_data)
  );

  // d is treated as 12-bit signed; bit 11 set means left of the sprite
  assign d        = {1'b0, hcount} - {1'b0, x_l};
  assign in_range = !d[11] && (d[10:0] < 11'(SPRITE_W));
  assign opaque   = hactive && line_hit && in_range && (rd_data != TRANSPARENT) && !busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid_r <= 1'b0;
      pix_color   <= '0;
    end else begin
      pix_valid_r <= opaque;
      if (opaque) pix_color <= rd_data;
    end
  end

  // a restart mid-line must not let a stale pixel through
  assign pix_valid = pix_valid_r && !busy;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
module tb_sprite_line_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sprite_en = 1'b0;
  logic [10:0] sprite_x = '0;
  logic [9:0]  sprite_y = '0;
  logic        line_start = 1'b0;
  logic [9:0]  next_line = '0;
  logic [10:0] hcount = '0;
  logic        hactive = 1'b0;
  logic [7:0]  rom_address;
  logic        rom_clken;
  logic [15:0] rom_readdata;
  logic        busy;
  logic        fetch_done;
  logic        pix_valid;
  logic [15:0] pix_color;

  logic [15:0] rom_mem [256];
  logic [15:0] rom_q = '0;
  int          rom_acc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  // registered-address ROM model
  always @(posedge clk) begin
    if (rom_clken) begin
      rom_q   <= rom_mem[rom_address];
      rom_acc <= rom_acc + 1;
    end
  end
  assign rom_readdata = rom_q;

  sprite_line_fetcher dut (
    .clk          (clk),
    .reset        (reset),
    .sprite_en    (sprite_en),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .line_start   (line_start),
    .next_line    (next_line),
    .hcount       (hcount),
    .hactive      (hactive),
    .rom_address  (rom_address),
    .rom_clken    (rom_clken),
    .rom_readdata (rom_readdata),
    .busy         (busy),
    .fetch_done   (fetch_done),
    .pix_valid    (pix_valid),
    .pix_color    (pix_color)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pulse line_start in cycle 0; returns in cycle 1
  task automatic pulse(input logic [9:0] line);
    next_line  = line;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!fetch_done && n < 40) begin
      tick();
      n++;
    end
    chk(tag, fetch_done, 1);
    tick();
  endtask

  // sweep hcount lo..hi and compare against the ROM row the sprite should show
  task automatic sweep(input string tag, input int x, input int row, input int lo,
                       input int hi, input bit hit);
    int   off;
    logic ev;
    logic [15:0] ec;
    for (int h = lo; h <= hi; h++) begin
      hcount  = 11'(h);
      hactive = 1'b1;
      tick();
      off = h - x;
      ec  = (off >= 0 && off < 16) ? rom_mem[row * 16 + off] : 16'h0;
      ev  = hit && off >= 0 && off < 16 && ec != 16'h0000;
      chk({tag, "_valid"}, pix_valid, ev);
      if (ev) chk({tag, "_color"}, pix_color, ec);
    end
    hactive = 1'b0;
    tick();
  endtask

  initial begin
    int acc0;
    int nd;
    for (int a = 0; a < 256; a++) rom_mem[a] = 16'(a);

    // reset state
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_clken", rom_clken, 0);
    chk("rst_done", fetch_done, 0);
    chk("rst_pix", pix_valid, 0);
    chk("rst_addr", rom_address, 0);
    chk("rst_color", pix_color, 0);
    reset = 1'b0;
    tick();

    // hit fetch: row 3, addresses 0x30..0x3F in cycles 1..16
    sprite_en = 1'b1;
    sprite_y  = 10'd100;
    sprite_x  = 11'd200;
    acc0      = rom_acc;
    pulse(10'd103);
    for (int c = 1; c <= 16; c++) begin
      chk("hit_addr", rom_address, 32'h30 + c - 1);
      chk("hit_clken", rom_clken, 1);
      chk("hit_busy", busy, 1);
      chk("hit_done_early", fetch_done, 0);
      tick();
    end
    chk("last_clken", rom_clken, 0);
    chk("last_busy", busy, 1);
    chk("last_done", fetch_done, 0);
    tick();
    chk("c18_done", fetch_done, 1);
    chk("c18_busy", busy, 0);
    tick();
    chk("c19_done", fetch_done, 0);
    chk("hit_rom_acc", rom_acc - acc0, 16);

    sweep("draw", 200, 3, 190, 220, 1'b1);

    // transparency: word 0x35 is clear, hcount 205 must be skipped
    rom_mem[8'h35] = 16'h0000;
    pulse(10'd103);
    wait_done("tr_done");
    sweep("transp", 200, 3, 198, 218, 1'b1);
    rom_mem[8'h35] = 16'h0035;

    // miss below the sprite
    acc0 = rom_acc;
    pulse(10'd116);
    chk("miss_done", fetch_done, 1);
    chk("miss_busy", busy, 0);
    chk("miss_clken", rom_clken, 0);
    tick();
    chk("miss_done_pulse", fetch_done, 0);
    sweep("miss", 200, 0, 195, 220, 1'b0);
    chk("miss_rom_acc", rom_acc - acc0, 0);

    // sprite near the bottom: line 5 must not wrap into a hit
    sprite_y = 10'd1020;
    acc0     = rom_acc;
    pulse(10'd5);
    chk("wrap_done", fetch_done, 1);
    chk("wrap_busy", busy, 0);
    tick();
    chk("wrap_rom_acc", rom_acc - acc0, 0);
    sweep("wrap", 200, 0, 198, 218, 1'b0);

    // line 1023 is row 3 of that same sprite
    pulse(10'd1023);
    chk("bot_addr", rom_address, 32'h30);
    chk("bot_busy", busy, 1);
    wait_done("bot_done");

    // left edge
    sprite_y = 10'd0;
    sprite_x = 11'd0;
    pulse(10'd2);
    chk("x0_addr", rom_address, 32'h20);
    wait_done("x0_done");
    sweep("x0", 0, 2, 0, 20, 1'b1);

    // abort at cycle 7 with a new line
    sprite_y = 10'd100;
    sprite_x = 11'd200;
    pulse(10'd103);
    for (int c = 1; c < 7; c++) tick();
    chk("ab_c7_addr", rom_address, 32'h36);
    pulse(10'd104);
    nd = 0;
    for (int c = 8; c <= 24; c++) begin
      if (c <= 23) chk("ab_addr", rom_address, 32'h40 + c - 8);
      if (fetch_done) nd++;
      tick();
    end
    chk("ab_no_early_done", nd, 0);
    chk("ab_done_c25", fetch_done, 1);
    tick();
    sweep("ab_draw", 200, 4, 198, 218, 1'b1);

    // reset at cycle 9 of a fetch
    pulse(10'd103);
    for (int c = 1; c < 9; c++) tick();
    chk("rs_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_clken", rom_clken, 0);
    chk("rs_pix", pix_valid, 0);
    chk("rs_done", fetch_done, 0);
    chk("rs_addr", rom_address, 0);
    #3;
    reset = 1'b0;
    acc0  = rom_acc;
    nd    = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (fetch_done) nd++;
    end
    chk("rs_no_done", nd, 0);
    chk("rs_rom_acc", rom_acc - acc0, 0);
    sweep("rs_draw", 200, 0, 198, 218, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
